// File: rtl/series_engine.sv
// Iterative fixed-point series evaluator for cos, sin and exp.
// Coefficients come from an external synchronous ROM, addressed by {mode, term index}.
module series_engine #(
    parameter int unsigned W        = 16,
    parameter int unsigned FRAC     = 14,
    parameter int unsigned MAXTERMS = 8,
    localparam int unsigned KW      = $clog2(MAXTERMS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [W-1:0]      x_in_i,
    input  logic [W-1:0]      thr_i,
    output logic              coef_rd_o,
    output logic [KW+1:0]     coef_addr_o,
    input  logic [W-1:0]      coef_data_i,
    output logic [W-1:0]      result_o,
    output logic [KW-1:0]     nterms_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              sat_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        StIdle, StArm, StInit, StPre, StMul1, StMul2, StAcc, StChk
    } state_e;

    localparam logic signed [W-1:0] One    = W'(1) << FRAC;
    localparam logic signed [W-1:0] MaxVal = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};
    localparam logic [KW-1:0]       MaxK   = KW'(MAXTERMS);

    state_e              state_q;
    logic [1:0]          mode_q;
    logic signed [W-1:0] x_q;
    logic [W-1:0]        thr_q;
    logic signed [W-1:0] term_q;
    logic signed [W-1:0] xp_q;
    logic signed [W-1:0] res_q;
    logic [KW-1:0]       k_q;
    logic                sat_q;
    logic                err_q;

    // Full-precision product, arithmetic shift (floors), then wrap to W bits.
    function automatic logic signed [W-1:0] fx_mul(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        p = p >>> FRAC;
        return p[W-1:0];
    endfunction

    logic                acc_sub;
    logic signed [W:0]   acc_sum;
    logic                acc_ovf;
    logic signed [W-1:0] acc_val;
    logic [W-1:0]        term_abs;

    always_comb begin
        acc_sub  = (mode_q != 2'd2) && !k_q[0];
        acc_sum  = acc_sub ? ({res_q[W-1], res_q} - {term_q[W-1], term_q})
                           : ({res_q[W-1], res_q} + {term_q[W-1], term_q});
        acc_ovf  = acc_sum[W] != acc_sum[W-1];
        acc_val  = acc_ovf ? (acc_sum[W] ? MinVal : MaxVal) : acc_sum[W-1:0];
        // The most negative value has no positive twin; clamp its magnitude.
        term_abs = (term_q == MinVal) ? MaxVal : (term_q[W-1] ? -term_q : term_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            mode_q  <= '0;
            x_q     <= '0;
            thr_q   <= '0;
            term_q  <= '0;
            xp_q    <= '0;
            res_q   <= '0;
            k_q     <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: if (start_i) state_q <= StArm;
                StArm:  if (!start_i) state_q <= StInit;
                StInit: begin
                    mode_q <= mode_i;
                    x_q    <= x_in_i;
                    thr_q  <= thr_i;
                    k_q    <= '0;
                    sat_q  <= 1'b0;
                    if (mode_i == 2'd3) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        err_q   <= 1'b0;
                        term_q  <= (mode_i == 2'd1) ? x_in_i : One;
                        res_q   <= (mode_i == 2'd1) ? x_in_i : One;
                        state_q <= StPre;
                    end
                end
                StPre: begin
                    xp_q    <= (mode_q == 2'd2) ? x_q : fx_mul(x_q, x_q);
                    state_q <= StMul1;
                end
                StMul1: begin
                    term_q  <= fx_mul(term_q, xp_q);
                    state_q <= StMul2;
                end
                StMul2: begin
                    term_q  <= fx_mul(term_q, coef_data_i);
                    state_q <= StAcc;
                end
                StAcc: begin
                    res_q   <= acc_val;
                    sat_q   <= sat_q | acc_ovf;
                    k_q     <= k_q + KW'(1);
                    state_q <= StChk;
                end
                StChk: begin
                    if ((term_abs < thr_q) || (k_q == MaxK)) state_q <= StIdle;
                    else                                     state_q <= StMul1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done_o      = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign coef_rd_o   = (state_q == StMul1);
    assign coef_addr_o = coef_rd_o ? {mode_q, k_q} : '0;
    assign result_o    = res_q;
    assign nterms_o    = k_q;
    assign sat_o       = sat_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_series_engine.sv
// Bench for series_engine: directed scenarios plus random runs against an arithmetic model
// of the series, with a behavioural synchronous coefficient ROM.
module tb_series_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] x_in;
    logic [15:0] thr;
    logic        coef_rd;
    logic [5:0]  coef_addr;
    logic [15:0] coef_data;
    logic [15:0] result;
    logic [3:0]  nterms;
    logic        done;
    logic        busy;
    logic        sat;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;
    int rom [64];
    int prev_result = 0;

    series_engine #(.W(16), .FRAC(14), .MAXTERMS(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .mode_i     (mode),
        .x_in_i     (x_in),
        .thr_i      (thr),
        .coef_rd_o  (coef_rd),
        .coef_addr_o(coef_addr),
        .coef_data_i(coef_data),
        .result_o   (result),
        .nterms_o   (nterms),
        .done_o     (done),
        .busy_o     (busy),
        .sat_o      (sat),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) coef_data <= 16'(rom[coef_addr]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int qmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        p = p >>> 14;
        return wrap16(p);
    endfunction

    // Textbook series: term_k = term_{k-1} * xp * c_k, alternating for cos/sin.
    task automatic model(input int md, input int xv, input int th,
                         output int res, output int n, output int s, output int e);
        int term, xp, mag;
        n = 0;
        s = 0;
        e = (md == 3) ? 1 : 0;
        if (md == 3) begin
            res = prev_result;
        end else begin
            term = (md == 1) ? xv : 16384;
            res  = term;
            xp   = (md == 2) ? xv : qmul(xv, xv);
            do begin
                term = qmul(qmul(term, xp), rom[md * 16 + n]);
                if (md != 2 && (n % 2) == 0) res = res - term;
                else                         res = res + term;
                if (res > 32767)  begin res = 32767;  s = 1; end
                if (res < -32768) begin res = -32768; s = 1; end
                n++;
                mag = (term < 0) ? -term : term;
                if (mag > 32767) mag = 32767;
            end while (!(mag < th || n == 8));
        end
    endtask

    // disturb: 0 none, 1 pulse start during first MUL1, 2 raise and hold start from first MUL1.
    task automatic do_run(input int md, input int xv, input int th, input int disturb,
                          output int cycles);
        int kexp;
        mode  = md[1:0];
        x_in  = xv[15:0];
        thr   = th[15:0];
        start = 1'b1;
        tick();
        check("arm_busy", busy, 1);
        start = 1'b0;
        tick();
        cycles = 0;
        kexp   = 0;
        while (!done && cycles < 100) begin
            tick();
            cycles++;
            if (disturb == 1 && start) start = 1'b0;
            if (coef_rd) begin
                check("coef_addr", coef_addr, md * 16 + kexp);
                kexp++;
                if (disturb != 0 && kexp == 1) start = 1'b1;
            end else begin
                check("coef_addr_idle", coef_addr, 0);
            end
        end
        check("done_timeout", done, 1);
        if (md == 3) check("mode3_no_coef_rd", kexp, 0);
    endtask

    task automatic run_and_check(input int md, input int xv, input int th, input int disturb);
        int cyc, er, en, es, ee;
        model(md, xv, th, er, en, es, ee);
        do_run(md, xv, th, disturb, cyc);
        check("result", $signed(result), er);
        check("err", err, ee);
        check("busy_end", busy, 0);
        if (md != 3) begin
            check("nterms", nterms, en);
            check("sat", sat, es);
            check("latency", cyc, 2 + 4 * en);
        end else begin
            check("latency_mode3", cyc, 1);
        end
        prev_result = er;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!done && c < 100) begin
            tick();
            c++;
        end
        check("wait_done_timeout", done, 1);
    endtask

    initial begin
        int d, tol, r;
        for (int k = 0; k < 16; k++) begin
            d = (2 * k + 1) * (2 * k + 2);
            rom[k] = (32768 + d) / (2 * d);
            d = (2 * k + 2) * (2 * k + 3);
            rom[16 + k] = (32768 + d) / (2 * d);
            d = k + 1;
            rom[32 + k] = (32768 + d) / (2 * d);
            rom[48 + k] = 0;
        end

        // Reset with start held high must not arm.
        rst   = 1'b1;
        start = 1'b1;
        mode  = 2'd0;
        x_in  = 16'd0;
        thr   = 16'd1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 1);
        check("rst_result", result, 0);
        check("rst_nterms", nterms, 0);
        check("rst_sat", sat, 0);
        check("rst_err", err, 0);
        check("rst_coef_rd", coef_rd, 0);
        check("rst_coef_addr", coef_addr, 0);
        rst = 1'b0;
        tick();
        check("post_rst_arm", busy, 1);
        start = 1'b0;
        wait_done();
        check("post_rst_result", result, 16384);
        prev_result = 16384;

        // cos(0), single term
        run_and_check(0, 0, 1, 0);
        check("cos0_result", result, 16384);
        check("cos0_nterms", nterms, 1);
        check("cos0_sat", sat, 0);

        // cos(0.5) close to the true value
        run_and_check(0, 8192, 4, 0);
        r   = $signed(result);
        tol = (r > 14378) ? r - 14378 : 14378 - r;
        check("cos_half_tol", (tol <= 2) ? 1 : 0, 1);

        // exp(1.0) saturates and runs to MAXTERMS
        run_and_check(2, 16384, 1, 0);
        check("exp1_sat", sat, 1);
        check("exp1_result", result, 32767);
        check("exp1_nterms", nterms, 8);

        // reserved mode
        run_and_check(3, 1234, 5, 0);
        check("mode3_result_kept", result, 16'(32767));

        // reset during MUL2 of the second term
        mode  = 2'd0;
        x_in  = 16'd8192;
        thr   = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        d = 0;
        while (!(coef_rd && coef_addr[3:0] == 4'd1) && d < 50) begin
            tick();
            d++;
        end
        check("reach_term2", coef_rd, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_nterms", nterms, 0);
        check("abort_sat", sat, 0);
        check("abort_err", err, 0);
        check("abort_coef_rd", coef_rd, 0);
        prev_result = 0;
        run_and_check(1, 12000, 2, 0);

        // start pulsed mid-run is ignored
        run_and_check(1, 12000, 2, 1);

        // start held through completion re-arms
        run_and_check(0, -10000, 3, 2);
        tick();
        check("rearm_busy", busy, 1);
        start = 1'b0;
        wait_done();
        check("rearm_result", $signed(result), prev_result);

        for (int i = 0; i < 12; i++) begin
            run_and_check(int'($urandom_range(0, 2)), int'($urandom_range(0, 32768)) - 16384,
                          int'($urandom_range(1, 200)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/series_engine.md
SERIES_ENGINE -- requirements
Module: series_engine

Interface
REQ-001 Parameter W, default 16: data width, signed two's-complement fixed point.
REQ-002 Parameter FRAC, default 14: fraction bits; 1.0 = 2^FRAC.
REQ-003 Parameter MAXTERMS, default 8: maximum series updates per evaluation; KW = clog2(MAXTERMS+1).
REQ-004 Ports: clk in 1, clock; all logic on rising edge; one clock; reset is synchronous and active-high.
REQ-005 Ports: rst in 1, synchronous active-high reset.
REQ-006 Ports: start in 1, start request, high-then-low handshake.
REQ-007 Ports: mode in 2, 0 = cos, 1 = sin, 2 = exp, 3 = reserved.
REQ-008 Ports: x_in in W, argument; thr in W, unsigned termination threshold on |term|.
REQ-009 Ports: coef_rd out 1, coefficient read strobe; coef_addr out 2+KW, {mode, k}.
REQ-010 Ports: coef_data in W, coefficient from external synchronous ROM, valid the cycle after coef_rd.
REQ-011 Ports: result out W; nterms out KW; done out 1; busy out 1; sat out 1; err out 1.

Function
REQ-012 States SHALL be IDLE, ARM, INIT, PRE, MUL1, MUL2, ACC, CHK.
REQ-013 IDLE: done=1, busy=0; start=1 -> ARM; otherwise stay.
REQ-014 ARM: stay while start=1; start=0 -> INIT; busy=1 from ARM through CHK.
REQ-015 INIT: latch mode, x_in, thr; k<=0; sat<=0; err<=0; term and res <= x_in for sin, 1.0 otherwise.
REQ-016 INIT with mode=3: err<=1, result unchanged, next state IDLE.
REQ-017 PRE: xp <= x*x for cos/sin, x for exp; next MUL1.
REQ-018 MUL1: term <= term*xp; coef_rd=1; coef_addr={mode_r,k}; next MUL2.
REQ-019 MUL2: term <= term*coef_data; next ACC.
REQ-020 Multiply: full 2W signed product arithmetically shifted right by FRAC, low W bits kept (truncation toward minus infinity, no saturation).
REQ-021 ACC: cos/sin res <= res - term for even k, res + term for odd k; exp always add; k <= k+1; next CHK.
REQ-022 ACC add/sub SHALL saturate to [-2^(W-1), 2^(W-1)-1]; any saturation sets sat, which stays set until next INIT.
REQ-023 CHK: |term| < thr or k == MAXTERMS -> IDLE; else MUL1. |-2^(W-1)| treated as 2^(W-1)-1.
REQ-024 Latency from first cycle start is low to done high: 2 + 4*nterms cycles.
REQ-025 result = res, nterms = k; both hold their value in IDLE until the next INIT.
REQ-026 start SHALL be ignored from INIT through CHK; a held start after completion re-arms via ARM.
REQ-027 coef_rd=0 and coef_addr=0 outside MUL1.

Reset
REQ-028 rst=1 at a clock edge -> IDLE on the same edge, from any state, with an evaluation in progress abandoned.
REQ-029 Reset values: result=0, nterms=0, sat=0, err=0, busy=0, coef_rd=0, done=1 (combinational in IDLE).
REQ-030 start high during reset SHALL NOT arm; after reset release, start=1 takes IDLE -> ARM.

Verification
REQ-031 cos, x=0, thr=1, ROM[0]=8192 -> term 0 after k=0; done 6 cycles after start low; result=16384, nterms=1, sat=0.
REQ-032 cos, x=8192 (0.5), thr=4, ROM cos k = 1/((2k+1)(2k+2)) -> result within 2 LSB of 14378 (cos 0.5); alternating add/sub checked on the internal ACC sign.
REQ-033 exp, x=16384 (1.0), thr=1, ROM exp k = 1/(k+1) -> sat=1, result=32767, nterms=MAXTERMS=8.
REQ-034 mode=3 -> done after ARM and INIT; err=1; result unchanged; coef_rd never asserted.
REQ-035 rst pulse during MUL2 of term 2 -> next cycle IDLE, done=1, outputs at reset values; a fresh start completes normally.
REQ-036 start pulsed again during MUL1 -> no effect; nterms and result match an undisturbed run.
